// File: rtl/vpifo_task_arbiter.sv
// Round-robin front-end for the virtualized PIFO: screens per-tree push/pop requests
// against logical occupancy and issues one {op, TreeId, payload} task word per cycle.
module vpifo_task_arbiter #(
  parameter int PTW           = 16,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int TREE_CAP      = 64,
  parameter int CNT_W         = $clog2(TREE_CAP + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TREE_NUM-1:0]          i_req,
  input  logic [TREE_NUM-1:0]          i_op,
  input  logic [TREE_NUM*PTW-1:0]      i_data,
  output logic [TREE_NUM-1:0]          o_grant,
  output logic [TREE_NUM-1:0]          o_reject,
  output logic                         fifo_wr_en,
  output logic [PTW+TREE_NUM_BITS:0]   fifo_buf_in,
  input  logic                         fifo_full,
  output logic [TREE_NUM*CNT_W-1:0]    o_tree_count
);

  localparam int WW = PTW + TREE_NUM_BITS + 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(TREE_CAP);

  logic [CNT_W-1:0]         r_count [TREE_NUM];
  logic [TREE_NUM_BITS-1:0] r_rr_ptr;
  logic                     r_out_valid;
  logic [WW-1:0]            r_out_word;

  logic [TREE_NUM-1:0]      w_elig;
  logic                     w_can_issue;
  logic                     w_found;
  logic                     w_grant_any;
  logic [TREE_NUM_BITS-1:0] w_cand;
  logic [TREE_NUM_BITS-1:0] w_gnt_idx;
  logic [WW-1:0]            w_gnt_word;

  function automatic logic [TREE_NUM_BITS-1:0] wrap_idx(input logic [TREE_NUM_BITS-1:0] base,
                                                        input int off);
    int s;
    s = int'(base) + off;
    s = (s >= TREE_NUM) ? (s - TREE_NUM) : s;
    return TREE_NUM_BITS'(s);
  endfunction

  always_comb begin
    w_elig = '0;
    for (int k = 0; k < TREE_NUM; k++) begin
      if (i_op[k]) begin
        w_elig[k] = i_req[k] && (r_count[k] != CAP);
      end else begin
        w_elig[k] = i_req[k] && (r_count[k] != '0);
      end
    end
  end

  // First eligible client strictly after the last granted one, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int i = 1; i <= TREE_NUM; i++) begin
      w_cand = wrap_idx(r_rr_ptr, i);
      if (!w_found && w_elig[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end else begin
        w_found   = w_found;
      end
    end
  end

  assign w_can_issue = !r_out_valid || !fifo_full;
  assign w_grant_any = !rst && w_found && w_can_issue;

  always_comb begin
    w_gnt_word = {i_op[w_gnt_idx], w_gnt_idx,
                  i_op[w_gnt_idx] ? i_data[int'(w_gnt_idx)*PTW +: PTW] : {PTW{1'b0}}};
  end

  always_comb begin
    o_grant  = '0;
    o_reject = '0;
    if (rst) begin
      o_reject = '0;
    end else begin
      o_reject = i_req & ~w_elig;
      if (w_grant_any) begin
        o_grant[w_gnt_idx] = 1'b1;
      end else begin
        o_grant = '0;
      end
    end
  end

  assign fifo_wr_en  = !rst && r_out_valid && !fifo_full;
  assign fifo_buf_in = r_out_valid ? r_out_word : '0;

  always_comb begin
    o_tree_count = '0;
    for (int k = 0; k < TREE_NUM; k++) begin
      o_tree_count[k*CNT_W +: CNT_W] = r_count[k];
    end
  end

  // Occupancy is logical: a pop frees its slot at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_rr_ptr    <= TREE_NUM_BITS'(TREE_NUM - 1);
      for (int k = 0; k < TREE_NUM; k++) begin
        r_count[k] <= '0;
      end
    end else if (w_grant_any) begin
      r_out_valid <= 1'b1;
      r_out_word  <= w_gnt_word;
      r_rr_ptr    <= w_gnt_idx;
      if (i_op[w_gnt_idx]) begin
        r_count[w_gnt_idx] <= r_count[w_gnt_idx] + CNT_W'(1);
      end else begin
        r_count[w_gnt_idx] <= r_count[w_gnt_idx] - CNT_W'(1);
      end
    end else if (fifo_wr_en) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

endmodule

// File: tb/tb_vpifo_task_arbiter.sv
// Directed plus randomized bench for vpifo_task_arbiter against a queue/array reference model.
module tb_vpifo_task_arbiter;
  localparam int PTW = 16;
  localparam int N   = 4;
  localparam int NB  = 2;
  localparam int CAP = 64;
  localparam int CW  = 7;
  localparam int WW  = PTW + NB + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      op  = '0;
  logic [N*PTW-1:0]  data = '0;
  logic              full = 1'b0;
  logic [N-1:0]      grant, reject;
  logic              wr_en;
  logic [WW-1:0]     buf_in;
  logic [N*CW-1:0]   tree_count;

  vpifo_task_arbiter dut (
    .clk(clk), .rst(rst), .i_req(req), .i_op(op), .i_data(data),
    .o_grant(grant), .o_reject(reject), .fifo_wr_en(wr_en), .fifo_buf_in(buf_in),
    .fifo_full(full), .o_tree_count(tree_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_cnt [N];
  int m_last;
  logic [WW-1:0] m_pend [$];
  logic [N-1:0] last_g, last_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_last = N - 1;
    m_pend.delete();
  endtask

  // One clock cycle: predict from model, check DUT, advance model. Called just after negedge.
  task automatic step(input logic r);
    logic [N-1:0]    eg, er;
    logic            ew, can;
    logic [WW-1:0]   eb, word;
    logic [N*CW-1:0] ec;
    int              gk;
    rst = r;
    eg = '0; er = '0; gk = -1;
    ew = !r && (m_pend.size() == 1) && !full;
    eb = (m_pend.size() == 1) ? m_pend[0] : '0;
    for (int k = 0; k < N; k++) ec[k*CW +: CW] = CW'(m_cnt[k]);
    if (!r) begin
      for (int k = 0; k < N; k++)
        if (req[k] && !(op[k] ? (m_cnt[k] < CAP) : (m_cnt[k] > 0))) er[k] = 1'b1;
      can = (m_pend.size() == 0) || !full;
      if (can)
        for (int off = 1; off <= N && gk < 0; off++) begin
          int k2;
          k2 = (m_last + off) % N;
          if (req[k2] && !er[k2]) gk = k2;
        end
      if (gk >= 0) eg[gk] = 1'b1;
    end
    #1;
    chk("grant", 64'(grant), 64'(eg));
    chk("reject", 64'(reject), 64'(er));
    chk("wr_en", 64'(wr_en), 64'(ew));
    chk("buf_in", 64'(buf_in), 64'(eb));
    chk("counts", 64'(tree_count), 64'(ec));
    last_g = eg;
    last_r = er;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (ew) void'(m_pend.pop_front());
      if (gk >= 0) begin
        word = {op[gk], NB'(gk), op[gk] ? data[gk*PTW +: PTW] : 16'h0000};
        m_pend.push_back(word);
        m_last = gk;
        m_cnt[gk] += op[gk] ? 1 : -1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int guard;
    int push_pct;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    step(1'b1);
    chk("reset_counts", 64'(tree_count), 64'h0);

    // Single push from client 0.
    req = 4'b0001; op = 4'b0001; data[15:0] = 16'hABCD;
    step(1'b0);
    chk("tp1_word", 64'(buf_in), 64'h4ABCD);
    chk("tp1_count0", 64'(tree_count[6:0]), 64'd1);
    req = '0;
    step(1'b0);

    // Pop to empty tree 2 is refused.
    req = 4'b0100; op = 4'b0000;
    step(1'b0);
    chk("tp2_count2", 64'(tree_count[20:14]), 64'd0);
    req = '0;
    step(1'b0);

    // All clients push continuously: rotation.
    for (int i = 0; i < 8; i++) begin
      req = 4'b1111; op = 4'b1111;
      data = {$urandom(), $urandom()};
      step(1'b0);
    end
    req = '0;
    step(1'b0);

    // Backpressure with two pending pushes.
    req = 4'b0011; op = 4'b0011; data = {$urandom(), $urandom()}; full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      req = req & ~last_g;
    end
    chk("bp_no_write", 64'(wr_en), 64'd0);
    full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      req = req & ~last_g;
    end

    // Fill tree 1 to capacity, then overflow push and a pop.
    req = 4'b0010; op = 4'b0010;
    guard = 0;
    while (m_cnt[1] < CAP && guard < 200) begin
      step(1'b0);
      req = 4'b0010;
      guard++;
    end
    chk("fill_count1", 64'(tree_count[13:7]), 64'd64);
    step(1'b0);
    op = 4'b0000;
    step(1'b0);
    chk("pop_word", 64'(buf_in), 64'h10000);
    chk("pop_count1", 64'(tree_count[13:7]), 64'd63);

    // Reset with a pending word and nonzero counts.
    req = '0;
    step(1'b1);
    chk("rst_counts", 64'(tree_count), 64'h0);
    chk("rst_no_write", 64'(wr_en), 64'd0);
    req = 4'b1001; op = 4'b1001;
    step(1'b0);
    req = req & ~last_g & ~last_r;
    step(1'b0);
    req = '0;

    // Randomized traffic: push-heavy then pop-heavy.
    for (int i = 0; i < 800; i++) begin
      push_pct = (i < 400) ? 80 : 25;
      for (int k = 0; k < N; k++) begin
        if (!req[k] && ($urandom_range(0, 99) < 60)) begin
          req[k] = 1'b1;
          op[k] = ($urandom_range(0, 99) < push_pct);
          data[k*PTW +: PTW] = 16'($urandom());
        end
      end
      full = ($urandom_range(0, 9) < 3);
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      req = req & ~(last_g | last_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vpifo_task_arbiter.md
# vpifo_task_arbiter

Upstream front-end of the virtualized BMW PIFO task path. It collects push/pop requests from `TREE_NUM` independent tree clients and arbitrates among them round-robin. It screens each request against a per-tree occupancy counter, rejecting pops to empty trees and pushes to full trees. Each granted request is encoded as a `{op, TreeId, data}` task word and written into the task FIFO one per cycle, respecting the FIFO's full flag.

## Interface
- `PTW`, 16, payload width
- `TREE_NUM`, 4, number of virtual trees/clients (≥2)
- `TREE_NUM_BITS`, `$clog2(TREE_NUM)`, tree-id width
- `TREE_CAP`, 64, max elements per virtual tree
- `CNT_W`, `$clog2(TREE_CAP+1)`, occupancy counter width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  TREE_NUM  per-client request valid; held until `o_grant` or `o_reject`
- `i_op`  in  TREE_NUM  per-client op: 1 = push, 0 = pop
- `i_data`  in  TREE_NUM*PTW  per-client push payload; client k occupies bits [k*PTW +: PTW]; ignored for pop
- `o_grant`  out  TREE_NUM  one-hot pulse: request accepted this cycle (combinational)
- `o_reject`  out  TREE_NUM  pulse: request refused and consumed this cycle (combinational)
- `fifo_wr_en`  out  1  write strobe to the task FIFO
- `fifo_buf_in`  out  PTW+TREE_NUM_BITS+1  task word {op, TreeId, payload}; payload is all-zero for pop
- `fifo_full`  in  1  task FIFO full flag
- `o_tree_count`  out  TREE_NUM*CNT_W  registered logical occupancy per tree

## Operation
- Eligibility per client k:
  - `i_req[k]` must be set.
  - A pop requires `count[k] != 0`.
  - A push requires `count[k] != TREE_CAP`.
- Rejection:
  - Every requesting, ineligible client gets `o_reject[k]` = 1 in that cycle, regardless of backpressure.
  - The client must drop the request.
  - Multiple rejects can occur in the same cycle.
- Issue slot: a single output register (`out_valid`, `out_word`).
  - `can_issue = !out_valid || !fifo_full`.
- Arbitration: when `can_issue` is set, grant the first eligible client searching from `rr_ptr+1` upward, wrapping modulo TREE_NUM.
  - At most one grant per cycle.
  - On a grant, `rr_ptr <= granted index`.
  - With no grant, `rr_ptr` holds.
- On grant to k:
  - `out_word <= {i_op[k], k, i_op[k] ? data_k : '0}` and `out_valid <= 1`.
  - `count[k]` increments on push and decrements on pop at the same edge.
- Drain:
  - `fifo_wr_en = out_valid && !fifo_full`.
  - `fifo_buf_in = out_word` whenever `out_valid` is set, else 0.
  - If the register drains with no new grant in that cycle, `out_valid <= 0`.
- Occupancy is logical: a pop decrements at grant time, not when the PIFO returns data.
- The arbiter never writes into a full FIFO, even if the FIFO would accept a simultaneous read/write.

## Timing
- Reset (synchronous; applies even mid-operation):
  - `out_valid`=0, all counts=0, `rr_ptr`=TREE_NUM-1, so tree 0 has first priority.
  - Any pending task word is discarded.
  - While `rst` is high, `o_grant`/`o_reject`/`fifo_wr_en` are forced to 0.
- Latency: a request granted in cycle N produces `fifo_wr_en` in cycle N+1 if `fifo_full`=0.
- Throughput: one task per cycle sustained while the FIFO is not full.
- Backpressure: while `fifo_full`=1 and `out_valid`=1, `out_word` holds, no grants are issued, and rejects still occur.
- Boundary conditions:
  - A push at `count=TREE_CAP-1` is granted; the next push to that tree is rejected.
  - A pop at `count=1` is granted; the next pop is rejected.
  - Counts never wrap.
- Within a cycle, `o_grant` and `o_reject` are mutually exclusive per client.
- Eligibility uses the registered counts. Only one request per client is outstanding, so there is no intra-cycle hazard.

## Test plan
- Reset, then client 0 pushes 0xABCD with `fifo_full`=0 → `o_grant`=0001 in cycle N; `fifo_wr_en`=1 with `fifo_buf_in`={1, 2'd0, 16'hABCD} in N+1; `count[0]`=1.
- Client 2 pops at `count[2]`=0 → `o_reject[2]`=1, no FIFO write, `count[2]` stays 0.
- All 4 clients push continuously → grants rotate 0,1,2,3,0,...; four consecutive FIFO writes carrying TreeIds 0,1,2,3.
- Hold `fifo_full`=1 for 5 cycles with 2 pending pushes → exactly one grant, then `out_word` stable and `fifo_wr_en`=0. After release, writes resume one per cycle with no loss or duplication.
- Fill tree 1 to 64 pushes → the 65th push is rejected. A pop is then granted with `fifo_buf_in`={0, 2'd1, 16'h0} and count 63.
- Assert `rst` for one cycle while `out_valid`=1 and counts are nonzero → no FIFO write follows, counts read 0, and the next simultaneous requests from clients 0 and 3 grant client 0 first.
